// File: rtl/pgm_sequencer.sv
// pgm_sequencer
//   Front-end of the 9-bit core. It streams instruction words into the
//   writable instruction memory starting at address 0, holding the core in
//   reset while loading. It then sequences a one-cycle core reset, a
//   one-cycle start pulse and a run phase that counts cycles until the
//   core's done flag. A program that never finishes is flagged as an error.
//
// Handshake: a word transfers on every cycle where LoadValid && LoadReady.
//   LoadReady depends only on state, never on LoadValid. While LoadValid is
//   high the producer holds LoadWord/LoadLast stable until the transfer.
//
// Ports:
//   Clk, Reset            clock (posedge), asynchronous active-high reset
//   LoadValid/LoadReady   load handshake for LoadWord/LoadLast
//   LoadWord, LoadLast    instruction word, last-word marker
//   RunReq                level request to execute the loaded program
//   ImemWe/Addr/Data      instruction memory write port
//   CoreReset, CoreStart  core control (reset level, start pulse)
//   CoreAck               core done flag
//   Busy, Done, ErrCode   status (ErrCode 01 load overflow, 10 run timeout)
//   WordCount, CycleCount program length, run cycles before done
//   DbgState              current FSM state, for observation only
module pgm_sequencer #(
    parameter int          W       = 9,
    parameter int          A       = 10,
    parameter int          CW      = 16,
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          LoadValid,
    output logic          LoadReady,
    input  logic [W-1:0]  LoadWord,
    input  logic          LoadLast,
    input  logic          RunReq,
    output logic          ImemWe,
    output logic [A-1:0]  ImemAddr,
    output logic [W-1:0]  ImemData,
    output logic          CoreReset,
    output logic          CoreStart,
    input  logic          CoreAck,
    output logic          Busy,
    output logic          Done,
    output logic [1:0]    ErrCode,
    output logic [A:0]    WordCount,
    output logic [CW-1:0] CycleCount,
    output logic [2:0]    DbgState
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_ARMED      = 3'd2,
        ST_RESET_CORE = 3'd3,
        ST_START      = 3'd4,
        ST_RUN        = 3'd5,
        ST_DONE       = 3'd6,
        ST_ERR        = 3'd7
    } state_t;

    localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT);
    localparam logic [1:0]    ERR_OVF   = 2'b01;
    localparam logic [1:0]    ERR_TMO   = 2'b10;

    state_t        r_state, w_state_next;
    logic [A-1:0]  r_addr,  w_addr_next;
    logic [A:0]    r_wc,    w_wc_next;
    logic [CW-1:0] r_cc,    w_cc_next;
    logic [1:0]    r_err,   w_err_next;

    logic          w_restart;
    logic [A-1:0]  w_addr_cur;
    logic          w_xfer;

    // A new program always begins at address 0, so in IDLE and DONE the
    // write address is forced to 0 regardless of where the last load ended.
    assign w_restart  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_addr_cur = w_restart ? '0 : r_addr;
    assign LoadReady  = (r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_DONE);
    assign w_xfer     = LoadValid && LoadReady;

    assign ImemWe     = w_xfer;
    assign ImemAddr   = w_addr_cur;
    assign ImemData   = LoadWord;

    assign CoreReset  = (r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_ARMED) ||
                        (r_state == ST_RESET_CORE) || (r_state == ST_ERR);
    assign CoreStart  = (r_state == ST_START);
    assign Busy       = (r_state == ST_RESET_CORE) || (r_state == ST_START) || (r_state == ST_RUN);
    assign Done       = (r_state == ST_DONE);
    assign ErrCode    = r_err;
    assign WordCount  = r_wc;
    assign CycleCount = r_cc;
    assign DbgState   = r_state;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wc    <= '0;
            r_cc    <= '0;
            r_err   <= 2'b00;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_wc    <= w_wc_next;
            r_cc    <= w_cc_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_wc_next    = r_wc;
        w_cc_next    = r_cc;
        w_err_next   = r_err;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                // A transfer takes priority over a rerun request from DONE.
                if (w_xfer) begin
                    w_addr_next  = w_addr_cur + 1'b1;
                    w_wc_next    = {{A{1'b0}}, 1'b1};
                    w_state_next = LoadLast ? ST_ARMED : ST_LOAD;
                end else if ((r_state == ST_DONE) && RunReq) begin
                    w_state_next = ST_RESET_CORE;
                end
            end
            ST_LOAD: begin
                if (w_xfer) begin
                    w_addr_next = w_addr_cur + 1'b1;
                    w_wc_next   = r_wc + 1'b1;
                    if (LoadLast) begin
                        w_state_next = ST_ARMED;
                    end else if (w_addr_cur == {A{1'b1}}) begin
                        // The word at the top address is written, but there
                        // is no room for the program to continue.
                        w_state_next = ST_ERR;
                        w_err_next   = ERR_OVF;
                    end
                end
            end
            ST_ARMED: begin
                if (RunReq) w_state_next = ST_RESET_CORE;
            end
            ST_RESET_CORE: begin
                w_cc_next    = '0;
                w_state_next = ST_START;
            end
            ST_START: begin
                // Ack may still be high from a previous run; it is not looked at here.
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (CoreAck) begin
                    w_state_next = ST_DONE;
                end else if (r_cc == TIMEOUT_V) begin
                    w_state_next = ST_ERR;
                    w_err_next   = ERR_TMO;
                end else begin
                    w_cc_next = r_cc + 1'b1;
                end
            end
            ST_ERR: begin
                w_state_next = ST_ERR;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pgm_sequencer.sv
// Testbench for pgm_sequencer, built with A=3 and TIMEOUT=20 so that the
// overflow and timeout corners are reachable in a short run.
module tb_pgm_sequencer;

    localparam int W  = 9;
    localparam int A  = 3;
    localparam int CW = 16;

    logic          Clk, Reset;
    logic          LoadValid, LoadReady, LoadLast, RunReq;
    logic [W-1:0]  LoadWord;
    logic          ImemWe;
    logic [A-1:0]  ImemAddr;
    logic [W-1:0]  ImemData;
    logic          CoreReset, CoreStart, CoreAck, Busy, Done;
    logic [1:0]    ErrCode;
    logic [A:0]    WordCount;
    logic [CW-1:0] CycleCount;
    logic [2:0]    DbgState;

    pgm_sequencer #(.W(W), .A(A), .CW(CW), .TIMEOUT(20)) dut (
        .Clk(Clk), .Reset(Reset),
        .LoadValid(LoadValid), .LoadReady(LoadReady),
        .LoadWord(LoadWord), .LoadLast(LoadLast), .RunReq(RunReq),
        .ImemWe(ImemWe), .ImemAddr(ImemAddr), .ImemData(ImemData),
        .CoreReset(CoreReset), .CoreStart(CoreStart), .CoreAck(CoreAck),
        .Busy(Busy), .Done(Done), .ErrCode(ErrCode),
        .WordCount(WordCount), .CycleCount(CycleCount), .DbgState(DbgState)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       lv, ll, rr, ack;
        logic [8:0] wd;
        logic       rdy, we;
        logic [2:0] ad;
        logic [8:0] dt;
        logic       cr, cs, bz, dn;
        logic [1:0] er;
        logic [3:0] wc;
        logic [15:0] cc;
    } vec_t;

    vec_t tbl[34];

    function automatic vec_t v(input logic lv, ll, rr, ack, input logic [8:0] wd,
                               input logic rdy, we, input logic [2:0] ad, input logic [8:0] dt,
                               input logic cr, cs, bz, dn, input logic [1:0] er,
                               input logic [3:0] wc, input logic [15:0] cc);
        vec_t r;
        r.lv = lv; r.ll = ll; r.rr = rr; r.ack = ack; r.wd = wd;
        r.rdy = rdy; r.we = we; r.ad = ad; r.dt = dt;
        r.cr = cr; r.cs = cs; r.bz = bz; r.dn = dn; r.er = er; r.wc = wc; r.cc = cc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic lv, ll, rr, ack, input logic [8:0] wd);
        LoadValid = lv; LoadLast = ll; RunReq = rr; CoreAck = ack; LoadWord = wd;
    endtask

    // one cycle: wait for edge, settle, then caller drives and checks
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [39:0] pack_out();
        return {LoadReady, ImemWe, ImemAddr, ImemData, CoreReset, CoreStart,
                Busy, Done, ErrCode, WordCount, CycleCount};
    endfunction

    function automatic logic [39:0] pack_exp(input vec_t e);
        return {e.rdy, e.we, e.ad, e.dt, e.cr, e.cs, e.bz, e.dn, e.er, e.wc, e.cc};
    endfunction

    // reset-state signature: ready, no write, addr 0, core in reset, counts 0
    function automatic logic [39:0] reset_sig();
        return {1'b1, 1'b0, 3'd0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'd0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int k;

    initial begin
        // rows: inputs | LoadReady, ImemWe, ImemAddr, ImemData, CoreReset, CoreStart, Busy, Done, ErrCode, WordCount, CycleCount
        tbl[0]  = v(0,0,0,0,9'h000, 1,0,3'd0,9'h000, 1,0,0,0,2'd0,4'd0,16'd0);
        tbl[1]  = v(1,0,0,0,9'h1A5, 1,1,3'd0,9'h1A5, 1,0,0,0,2'd0,4'd0,16'd0);
        tbl[2]  = v(1,0,0,0,9'h000, 1,1,3'd1,9'h000, 1,0,0,0,2'd0,4'd1,16'd0);
        tbl[3]  = v(1,1,0,0,9'h1FF, 1,1,3'd2,9'h1FF, 1,0,0,0,2'd0,4'd2,16'd0);
        tbl[4]  = v(0,0,0,0,9'h000, 0,0,3'd3,9'h000, 1,0,0,0,2'd0,4'd3,16'd0);
        tbl[5]  = v(1,0,0,0,9'h055, 0,0,3'd3,9'h055, 1,0,0,0,2'd0,4'd3,16'd0);
        tbl[6]  = v(0,0,1,0,9'h000, 0,0,3'd3,9'h000, 1,0,0,0,2'd0,4'd3,16'd0);
        tbl[7]  = v(0,0,0,0,9'h000, 0,0,3'd3,9'h000, 1,0,1,0,2'd0,4'd3,16'd0);
        tbl[8]  = v(0,0,0,0,9'h000, 0,0,3'd3,9'h000, 0,1,1,0,2'd0,4'd3,16'd0);
        for (int i = 0; i < 7; i++)
            tbl[9+i] = v(0,0,0,0,9'h000, 0,0,3'd3,9'h000, 0,0,1,0,2'd0,4'd3,16'(i));
        tbl[16] = v(0,0,0,1,9'h000, 0,0,3'd3,9'h000, 0,0,1,0,2'd0,4'd3,16'd7);
        tbl[17] = v(0,0,0,1,9'h000, 1,0,3'd0,9'h000, 0,0,0,1,2'd0,4'd3,16'd7);
        tbl[18] = v(0,0,1,1,9'h000, 1,0,3'd0,9'h000, 0,0,0,1,2'd0,4'd3,16'd7);
        tbl[19] = v(0,0,0,1,9'h000, 0,0,3'd3,9'h000, 1,0,1,0,2'd0,4'd3,16'd7);
        tbl[20] = v(0,0,0,1,9'h000, 0,0,3'd3,9'h000, 0,1,1,0,2'd0,4'd3,16'd0);
        for (int i = 0; i < 4; i++)
            tbl[21+i] = v(0,0,0,0,9'h000, 0,0,3'd3,9'h000, 0,0,1,0,2'd0,4'd3,16'(i));
        tbl[25] = v(0,0,0,1,9'h000, 0,0,3'd3,9'h000, 0,0,1,0,2'd0,4'd3,16'd4);
        tbl[26] = v(0,0,0,0,9'h000, 1,0,3'd0,9'h000, 0,0,0,1,2'd0,4'd3,16'd4);
        tbl[27] = v(0,0,1,0,9'h000, 1,0,3'd0,9'h000, 0,0,0,1,2'd0,4'd3,16'd4);
        tbl[28] = v(0,0,0,0,9'h000, 0,0,3'd3,9'h000, 1,0,1,0,2'd0,4'd3,16'd4);
        tbl[29] = v(0,0,0,0,9'h000, 0,0,3'd3,9'h000, 0,1,1,0,2'd0,4'd3,16'd0);
        tbl[30] = v(0,0,0,1,9'h000, 0,0,3'd3,9'h000, 0,0,1,0,2'd0,4'd3,16'd0);
        tbl[31] = v(0,0,0,0,9'h000, 1,0,3'd0,9'h000, 0,0,0,1,2'd0,4'd3,16'd0);
        tbl[32] = v(1,1,1,0,9'h0AB, 1,1,3'd0,9'h0AB, 0,0,0,1,2'd0,4'd3,16'd0);
        tbl[33] = v(0,0,0,0,9'h000, 0,0,3'd1,9'h000, 1,0,0,0,2'd0,4'd1,16'd0);

        // reset values while Reset is held, before any clock edge
        drive(0,0,0,0,9'h000);
        Reset = 1'b1;
        #2;
        chk("reset_hold", pack_out(), reset_sig());
        cyc();
        Reset = 1'b0;

        // table: load 3 words, run 7 cycles, rerun with stale Ack, halt on first
        // instruction, then transfer beats RunReq from DONE
        for (int i = 0; i < 34; i++) begin
            cyc();
            drive(tbl[i].lv, tbl[i].ll, tbl[i].rr, tbl[i].ack, tbl[i].wd);
            #1;
            chk($sformatf("row%0d", i), pack_out(), pack_exp(tbl[i]));
        end

        // run timeout: from ARMED, Ack stuck low
        cyc(); drive(0,0,1,0,9'h000);
        cyc(); drive(0,0,0,0,9'h000);
        k = 0;
        while (ErrCode == 2'b00 && k < 60) begin
            cyc();
            k++;
        end
        chk("tmo_errcode", 40'(ErrCode), 40'(2'b10));
        chk("tmo_cycles",  40'(CycleCount), 40'd20);
        chk("tmo_status",  40'({CoreReset, LoadReady, Busy, Done}), 40'(4'b1000));
        for (int i = 0; i < 3; i++) begin
            drive(1,1,1,0,9'h1C3);
            #1;
            chk($sformatf("err_no_we%0d", i), 40'(ImemWe), 40'd0);
            cyc();
        end
        chk("err_hold", 40'({ErrCode, WordCount, CycleCount, CoreReset}), 40'({2'b10, 4'd1, 16'd20, 1'b1}));

        // load overflow: 9 words, no LoadLast
        drive(0,0,0,0,9'h000);
        #2 Reset = 1'b1;
        #2 Reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            drive(1,0,0,0,9'(i*37 + 1));
            #1;
            if (i < 8)
                chk($sformatf("ovf_wr%0d", i), 40'({ImemWe, ImemAddr, ImemData}),
                    40'({1'b1, 3'(i), 9'(i*37 + 1)}));
            else
                chk("ovf_no_wr", 40'({ImemWe, LoadReady}), 40'd0);
        end
        cyc();
        drive(0,0,0,0,9'h000);
        chk("ovf_status", 40'({ErrCode, WordCount, LoadReady, CoreReset}), 40'({2'b01, 4'd8, 1'b0, 1'b1}));

        // async reset mid-LOAD
        #2 Reset = 1'b1;
        #2 Reset = 1'b0;
        cyc(); drive(1,0,0,0,9'h011);
        cyc(); drive(1,0,0,0,9'h022);
        cyc(); drive(0,0,0,0,9'h000);
        chk("mid_load_pre", 40'(WordCount), 40'd2);
        #2 Reset = 1'b1;
        #1;
        chk("mid_load_rst", pack_out(), reset_sig());
        #1 Reset = 1'b0;

        // async reset mid-RUN
        cyc(); drive(1,1,0,0,9'h033);
        cyc(); drive(0,0,1,0,9'h000);
        cyc(); drive(0,0,0,0,9'h000);
        cyc();
        cyc();
        cyc();
        chk("mid_run_pre", 40'({Busy, CoreReset, CycleCount}), 40'({1'b1, 1'b0, 16'd1}));
        #2 Reset = 1'b1;
        #1;
        chk("mid_run_rst", pack_out(), reset_sig());
        #1 Reset = 1'b0;

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pgm_sequencer.md
Name: pgm_sequencer

Overview:
- Upstream front-end of the 9-bit core.
- Accepts a stream of 9-bit instruction words and writes them into the writable instruction memory from address 0.
- Holds the core in reset while loading.
- Then sequences core reset, a one-cycle Start pulse, and waits for the core's Ack done flag, counting execution cycles and flagging runaway programs.

Parameters:
W, 9, instruction word width
A, 10, instruction memory address width (program counter width)
CW, 16, cycle counter width
TIMEOUT, 16'hFFFF, RUN cycles without Ack before error

Ports:
Clk  in  1  clock, posedge
Reset  in  1  asynchronous, active-high reset
LoadValid  in  1  LoadWord/LoadLast valid
LoadReady  out  1  sequencer accepts a word this cycle
LoadWord  in  W  instruction word
LoadLast  in  1  final word of program
RunReq  in  1  request program execution (level, sampled per cycle)
ImemWe  out  1  instruction memory write enable
ImemAddr  out  A  instruction memory write address
ImemData  out  W  instruction memory write data
CoreReset  out  1  reset to core, active high
CoreStart  out  1  start pulse to core
CoreAck  in  1  core done flag
Busy  out  1  state is RESET_CORE, START or RUN
Done  out  1  state is DONE
ErrCode  out  2  00 none, 01 load overflow, 10 run timeout
WordCount  out  A+1  words in loaded program
CycleCount  out  CW  RUN cycles before Ack

Behaviour:
- Reset (async): state IDLE, address 0, WordCount=0, CycleCount=0, ErrCode=00.
  - Outputs during/after Reset: LoadReady=1, CoreReset=1, CoreStart=0, ImemWe=0, Busy=0, Done=0.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs except ImemWe/ImemAddr/ImemData.
- A transfer occurs when LoadValid && LoadReady.
  - ImemWe = transfer, ImemData = LoadWord, ImemAddr = current write address, all in the same cycle.
  - The address increments on the next edge.
- States:
  - IDLE: LoadReady=1, CoreReset=1.
    - Transfer -> LOAD (or ARMED if LoadLast). Address restarts at 0; WordCount set to 1.
    - RunReq ignored.
  - LOAD: LoadReady=1, CoreReset=1.
    - Each transfer: WordCount+1.
    - LoadLast -> ARMED.
    - Transfer at address 2^A-1 without LoadLast -> ERR, ErrCode=01 (that word is still written).
    - RunReq ignored.
  - ARMED: LoadReady=0, CoreReset=1. RunReq -> RESET_CORE.
  - RESET_CORE (1 cycle): CoreReset=1; clears CycleCount -> START.
  - START (1 cycle): CoreReset=0, CoreStart=1 -> RUN. CoreAck ignored here.
  - RUN: CoreReset=0.
    - CoreAck=1 -> DONE; CycleCount frozen.
    - CoreAck=0: CycleCount+1.
    - CycleCount==TIMEOUT with CoreAck=0 -> ERR, ErrCode=10, CycleCount saturates at TIMEOUT.
    - LoadValid ignored (LoadReady=0).
  - DONE: Done=1, CoreReset=0 (core stays halted; Ack remains valid); LoadReady=1.
    - RunReq -> RESET_CORE (rerun same program, WordCount unchanged).
    - A transfer starts a new program at address 0, as from IDLE, and clears Done.
    - If RunReq and a transfer occur in the same cycle, the transfer wins.
  - ERR: CoreReset=1, LoadReady=0.
    - Exits only via Reset.
    - ErrCode, WordCount and CycleCount hold.
- Halt on first instruction: CoreAck=1 in the first RUN cycle gives CycleCount=0.
- Reset mid-operation (any state): immediate return to IDLE with reset values. Instruction memory contents are not cleared.

Test Plan:
- Load 3 words 0x1A5, 0x000, 0x1FF with LoadLast on the third -> ImemWe pulses at addresses 0,1,2 with matching data; state ARMED, WordCount=3, CoreReset=1.
- Then RunReq=1 for one cycle -> 1 cycle CoreReset=1, then 1 cycle CoreStart=1/CoreReset=0, then RUN. CoreAck rises after 7 RUN cycles -> Done=1, CycleCount=7, Busy=0.
- From DONE, RunReq again with CoreAck held high through START, low for 4 RUN cycles, then high -> CycleCount=4 (stale Ack in START ignored).
- TIMEOUT=20, CoreAck stuck 0 -> ERR, ErrCode=10, CycleCount=20, CoreReset=1. Further RunReq/LoadValid ignored until Reset.
- A=3: stream 9 words with no LoadLast -> 8 writes (addresses 0..7), ERR with ErrCode=01, WordCount=8, LoadReady=0 thereafter.
- Assert Reset asynchronously mid-RUN and mid-LOAD -> outputs return to reset values without a clock edge; LoadValid with LoadReady=0 (e.g. during ARMED/RUN) produces no ImemWe.
